// File: rtl/fb_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fb_rd_arbiter_if
//  Brief    : Requester/BRAM-side bundle of the frame-buffer read arbiter.
//             The slave modport is the arbiter's view; master is the
//             view of whoever drives requests and the BRAM read data.
//  Revision : 1.0  initial release
// ============================================================================
interface fb_rd_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              i_de;
    logic              i_frame;
    logic              i_disp_req;
    logic [ADDR_W-1:0] i_disp_addr;
    logic              o_disp_gnt;
    logic              o_disp_vld;
    logic [DATA_W-1:0] o_disp_data;
    logic              i_aux_req;
    logic [ADDR_W-1:0] i_aux_addr;
    logic              o_aux_gnt;
    logic              o_aux_vld;
    logic [DATA_W-1:0] o_aux_data;
    logic [ADDR_W-1:0] o_addrb;
    logic [DATA_W-1:0] i_doutb;
    logic              o_aux_starve;

    modport slave (
        input  i_de, i_frame,
        input  i_disp_req, i_disp_addr,
        input  i_aux_req, i_aux_addr,
        input  i_doutb,
        output o_disp_gnt, o_disp_vld, o_disp_data,
        output o_aux_gnt, o_aux_vld, o_aux_data,
        output o_addrb, o_aux_starve
    );

    modport master (
        output i_de, i_frame,
        output i_disp_req, i_disp_addr,
        output i_aux_req, i_aux_addr,
        output i_doutb,
        input  o_disp_gnt, o_disp_vld, o_disp_data,
        input  o_aux_gnt, o_aux_vld, o_aux_data,
        input  o_addrb, o_aux_starve
    );
endinterface
`default_nettype wire

// File: rtl/fb_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_rd_arbiter
//  Brief    : Shares the frame-buffer BRAM read port between display scan-out
//             (owner 0) and an aux reader (owner 1). Strict display priority
//             while i_de=1, round-robin in blanking. A {valid,owner} tag pipe
//             follows each read through the BRAM latency and steers the
//             returned word to its owner.
//  Options  : FB_ARB_STARVE_GUARD_EN - when defined, an aux requester that has
//             waited AUX_MAX_WAIT cycles in priority mode wins one cycle over
//             display. Undefined: starvation is only reported on o_aux_starve.
//  Revision : 1.0  initial release
// ============================================================================
module fb_rd_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int AUX_MAX_WAIT = 64
) (
    input  logic               clk,
    input  logic               rst,
    fb_rd_arbiter_if.slave     bus
);

    localparam int                  c_WAIT_W   = $clog2(AUX_MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(AUX_MAX_WAIT);

    // Round-robin pointer names the requester that wins the next tie.
    typedef enum logic [0:0] {
        RR_DISP = 1'b0,
        RR_AUX  = 1'b1
    } rr_t;

    rr_t                 r_rr_ptr;
    logic [ADDR_W-1:0]   r_addrb;
    logic [RD_LAT:0]     r_tag_vld;
    logic [RD_LAT:0]     r_tag_own;   // 1 = aux, 0 = display
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic                w_disp_gnt;
    logic                w_aux_gnt;
    logic                w_guard;
    logic                w_wait_full;
    logic [c_WAIT_W-1:0] w_wait_nxt;

    assign w_wait_full = (r_wait_cnt == c_WAIT_MAX);

`ifdef FB_ARB_STARVE_GUARD_EN
    // Starved aux steals exactly one priority-mode slot from display.
    assign w_guard = bus.i_aux_req && w_wait_full;
`else
    assign w_guard = 1'b0;
`endif

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        w_disp_gnt = 1'b0;
        w_aux_gnt  = 1'b0;
        if (!rst) begin
            if (bus.i_de) begin
                if (w_guard) begin
                    w_aux_gnt = 1'b1;
                end else if (bus.i_disp_req) begin
                    w_disp_gnt = 1'b1;
                end else if (bus.i_aux_req) begin
                    w_aux_gnt = 1'b1;
                end
            end else begin
                if (bus.i_disp_req && bus.i_aux_req) begin
                    w_disp_gnt = (r_rr_ptr == RR_DISP);
                    w_aux_gnt  = (r_rr_ptr == RR_AUX);
                end else begin
                    w_disp_gnt = bus.i_disp_req;
                    w_aux_gnt  = bus.i_aux_req;
                end
            end
        end
    end

    // Next aux wait count: saturating, cleared by grant, idle or frame start.
    always_comb begin
        w_wait_nxt = '0;
        if (bus.i_frame || !bus.i_aux_req || w_aux_gnt) begin
            w_wait_nxt = '0;
        end else if (w_wait_full) begin
            w_wait_nxt = r_wait_cnt;
        end else begin
            w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
        end
    end

    // Register the accepted address; hold it when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addrb <= '0;
        end else if (w_disp_gnt) begin
            r_addrb <= bus.i_disp_addr;
        end else if (w_aux_gnt) begin
            r_addrb <= bus.i_aux_addr;
        end
    end

    // Tag pipe: stage RD_LAT lines up with the BRAM word for that read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[RD_LAT-1:0], (w_disp_gnt | w_aux_gnt)};
            r_tag_own <= {r_tag_own[RD_LAT-1:0], w_aux_gnt};
        end
    end

    // Round-robin pointer: frame start re-arms display, else loser of last grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= RR_DISP;
        end else if (bus.i_frame) begin
            r_rr_ptr <= RR_DISP;
        end else if (w_disp_gnt) begin
            r_rr_ptr <= RR_AUX;
        end else if (w_aux_gnt) begin
            r_rr_ptr <= RR_DISP;
        end
    end

    // Aux wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
        end
    end

    assign bus.o_disp_gnt   = w_disp_gnt;
    assign bus.o_aux_gnt    = w_aux_gnt;
    assign bus.o_addrb      = r_addrb;
    assign bus.o_disp_vld   = r_tag_vld[RD_LAT] & ~r_tag_own[RD_LAT];
    assign bus.o_aux_vld    = r_tag_vld[RD_LAT] &  r_tag_own[RD_LAT];
    assign bus.o_disp_data  = bus.i_doutb;
    assign bus.o_aux_data   = bus.i_doutb;
    // Pulse in the cycle whose closing edge brings the counter to its limit.
    assign bus.o_aux_starve = !rst && !w_wait_full && (w_wait_nxt == c_WAIT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_fb_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_rd_arbiter
//  Brief    : Directed self-checking bench for fb_rd_arbiter. Three instances
//             (RD_LAT = 1, 2, 4), each with its own BRAM model whose word at
//             address a is a ^ 0x5A3C.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fb_rd_arbiter;

    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 16;
    localparam int AUX_MAX_WAIT = 64;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fb_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bus1 ();
    fb_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bus2 ();
    fb_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bus4 ();

    fb_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .AUX_MAX_WAIT(AUX_MAX_WAIT))
        u_dut1 (.clk(clk), .rst(rst),  .bus(u_bus1.slave));
    fb_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .AUX_MAX_WAIT(AUX_MAX_WAIT))
        u_dut2 (.clk(clk), .rst(rst),  .bus(u_bus2.slave));
    fb_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(4), .AUX_MAX_WAIT(AUX_MAX_WAIT))
        u_dut4 (.clk(clk), .rst(rst4), .bus(u_bus4.slave));

    function automatic logic [15:0] mem_f(input logic [14:0] a);
        return {1'b0, a} ^ 16'h5A3C;
    endfunction

    // BRAM models: address sampled on the edge, word emerges RD_LAT edges later.
    logic [15:0] r_bq1;
    logic [15:0] r_bq2 [2];
    logic [15:0] r_bq4 [4];

    always @(posedge clk) begin
        r_bq1    <= mem_f(u_bus1.o_addrb);
        r_bq2[0] <= mem_f(u_bus2.o_addrb);
        r_bq2[1] <= r_bq2[0];
        r_bq4[0] <= mem_f(u_bus4.o_addrb);
        for (int i = 1; i < 4; i++) r_bq4[i] <= r_bq4[i-1];
    end

    assign u_bus1.i_doutb = r_bq1;
    assign u_bus2.i_doutb = r_bq2[1];
    assign u_bus4.i_doutb = r_bq4[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Display-side sweep expectation: grant in cycle c returns in cycle c+L+1.
    task automatic chk_sweep(input string tag, input int lat, input int c,
                             input logic vld, input logic [15:0] data);
        logic        ev;
        logic [15:0] ed;
        ev = (c >= lat + 1) && (c <= lat + 16);
        ed = ev ? mem_f(15'(32'h40 + c - lat - 1)) : 16'h0;
        check(tag, {15'b0, vld, (vld ? data : 16'h0)}, {15'b0, ev, ed});
    endtask

    task automatic drv1(input logic de, input logic frame, input logic dreq, input logic areq);
        u_bus1.i_de       = de;
        u_bus1.i_frame    = frame;
        u_bus1.i_disp_req = dreq;
        u_bus1.i_aux_req  = areq;
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [2:0]  exp_s;
        logic [14:0] ad;
        logic [14:0] aa;

        rst  = 1'b1;
        rst4 = 1'b1;
        drv1(1'b1, 1'b0, 1'b1, 1'b1);
        u_bus1.i_disp_addr = 15'h0100;
        u_bus1.i_aux_addr  = 15'h0200;
        u_bus2.i_de = 1'b1; u_bus2.i_frame = 1'b0; u_bus2.i_disp_req = 1'b0;
        u_bus2.i_aux_req = 1'b0; u_bus2.i_disp_addr = '0; u_bus2.i_aux_addr = '0;
        u_bus4.i_de = 1'b1; u_bus4.i_frame = 1'b0; u_bus4.i_disp_req = 1'b0;
        u_bus4.i_aux_req = 1'b0; u_bus4.i_disp_addr = '0; u_bus4.i_aux_addr = '0;

        // Reset held with both requesters active.
        repeat (3) begin
            @(negedge clk); #1;
            check("rst_gnt_vld_starve", {27'b0, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt,
                  u_bus1.o_disp_vld, u_bus1.o_aux_vld, u_bus1.o_aux_starve}, 32'h0);
            check("rst_addrb", {17'b0, u_bus1.o_addrb}, 32'h0);
        end

        // Priority mode: display wins every cycle.
        @(negedge clk);
        rst = 1'b0; rst4 = 1'b0;
        #1;
        check("first_gnt", {30'b0, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt}, 32'h2);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            check("prio_gnt", {30'b0, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt}, 32'h2);
            check("prio_addrb", {17'b0, u_bus1.o_addrb}, 32'h0100);
            if (k == 1) begin
                check("prio_vld_lat", {30'b0, u_bus1.o_disp_vld, u_bus1.o_aux_vld}, 32'h0);
            end else begin
                check("prio_vld", {30'b0, u_bus1.o_disp_vld, u_bus1.o_aux_vld}, 32'h2);
                check("prio_data", {16'b0, u_bus1.o_disp_data}, {16'b0, mem_f(15'h0100)});
            end
        end

        // Idle frame pulse re-arms display as the tie winner.
        @(negedge clk);
        drv1(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("idle_gnt", {30'b0, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt}, 32'h0);

        // Round-robin: D,A,D,A... with returns in the same order.
        ad = 15'h0010;
        aa = 15'h0020;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                drv1(1'b0, 1'b0, 1'b1, 1'b1);
                u_bus1.i_disp_addr = ad;
                u_bus1.i_aux_addr  = aa;
            end
            #1;
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            check("rr_gnt", {30'b0, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt}, {30'b0, exp_g});
            if (k >= 1)
                check("rr_addrb", {17'b0, u_bus1.o_addrb}, {17'b0, ((k - 1) % 2 == 0) ? ad : aa});
            if (k >= 2) begin
                exp_g = ((k - 2) % 2 == 0) ? 2'b10 : 2'b01;
                check("rr_vld", {30'b0, u_bus1.o_disp_vld, u_bus1.o_aux_vld}, {30'b0, exp_g});
                if (exp_g == 2'b10)
                    check("rr_disp_data", {16'b0, u_bus1.o_disp_data}, {16'b0, mem_f(ad)});
                else
                    check("rr_aux_data", {16'b0, u_bus1.o_aux_data}, {16'b0, mem_f(aa)});
            end
        end

        // Starvation: aux waits behind display in priority mode.
        @(negedge clk);
        drv1(1'b1, 1'b0, 1'b0, 1'b0);
        for (int w = 1; w <= 70; w++) begin
            @(negedge clk);
            if (w == 1) begin
                drv1(1'b1, 1'b0, 1'b1, 1'b1);
                u_bus1.i_disp_addr = 15'h0300;
            end
            #1;
`ifdef FB_ARB_STARVE_GUARD_EN
            exp_s = {(w == 64), (w != 65), (w == 65)};
`else
            exp_s = {(w == 64), 1'b1, 1'b0};
`endif
            check($sformatf("starve_w%0d", w),
                  {29'b0, u_bus1.o_aux_starve, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt},
                  {29'b0, exp_s});
        end

        // Flush, then 16 back-to-back display reads on all three latencies.
        @(negedge clk);
        drv1(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int c = 0; c < 22; c++) begin
            if (c > 0) @(negedge clk);
            u_bus1.i_disp_req  = (c < 16);
            u_bus2.i_disp_req  = (c < 16);
            u_bus4.i_disp_req  = (c < 16);
            u_bus1.i_disp_addr = 15'(32'h40 + c);
            u_bus2.i_disp_addr = 15'(32'h40 + c);
            u_bus4.i_disp_addr = 15'(32'h40 + c);
            #1;
            chk_sweep($sformatf("sweep_l1_c%0d", c), 1, c, u_bus1.o_disp_vld, u_bus1.o_disp_data);
            chk_sweep($sformatf("sweep_l2_c%0d", c), 2, c, u_bus2.o_disp_vld, u_bus2.o_disp_data);
            chk_sweep($sformatf("sweep_l4_c%0d", c), 4, c, u_bus4.o_disp_vld, u_bus4.o_disp_data);
        end

        // Reset in flight on the RD_LAT=4 instance: issued reads never return.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            u_bus4.i_disp_req  = (c <= 4);
            u_bus4.i_disp_addr = 15'(32'h70 + c);
            rst4 = (c == 3) || (c == 4);
            #1;
            if (c < 3)
                check("mid_gnt", {31'b0, u_bus4.o_disp_gnt}, 32'h1);
            else if (c <= 4)
                check("mid_rst_gnt", {31'b0, u_bus4.o_disp_gnt}, 32'h0);
            if (c >= 3)
                check($sformatf("mid_no_vld_c%0d", c),
                      {30'b0, u_bus4.o_disp_vld, u_bus4.o_aux_vld}, 32'h0);
            if (c == 5)
                check("mid_addrb", {17'b0, u_bus4.o_addrb}, 32'h0);
        end

        // Frame pulse in blanking: same-cycle tie uses old pointer, later ties go to display.
        @(negedge clk);
        drv1(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("frm_d_only", {30'b0, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt}, 32'h2);
        @(negedge clk);
        drv1(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        check("frm_same_cycle", {30'b0, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt}, 32'h1);
        @(negedge clk);
        drv1(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("frm_tie_after", {30'b0, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt}, 32'h2);
        @(negedge clk);
        drv1(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("frm_idle", {30'b0, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt}, 32'h0);
        @(negedge clk);
        drv1(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("frm_tie_rearm", {30'b0, u_bus1.o_disp_gnt, u_bus1.o_aux_gnt}, 32'h2);

        @(negedge clk);
        drv1(1'b0, 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
